// File: rtl/gpr_interlock_ctl.sv
`default_nettype none
// ============================================================================
// Module   : gpr_interlock_ctl
// Purpose  : Issue-interlock scheduler for the 4-read/2-write GPR file.
//            Tracks in-flight destinations of both issue lanes through the
//            execute stages, plus one multi-cycle long-op unit, and stalls
//            issue while any source is not yet forwardable from the EX1/EX2
//            bypass.
// Ports    : clock, reset (async, active-low)
//            hold        - global pipeline hold, freezes all state
//            issValid    - decode bundle valid
//            regIdRs/Rt  - lane-1 sources, regIdRu/Rv - lane-2 sources
//            regIdRnA/B  - lane-1/lane-2 destinations (ZZR = none)
//            latClsA/B   - result class 0=EX1 1=EX2 2=EX3 3=long-op
//            longDone    - long-op result pulse
//            stall       - issue interlock (combinational)
//            longBusy    - long-op unit occupied
//            longDst     - destination of the active long-op (ZZR if idle)
//            tmoErr      - sticky long-op watchdog error
// Options  : `define GPR_INTERLOCK_LONGTMO_EN enables the long-op watchdog
//            (LONG_TMO cycles); otherwise tmoErr is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_interlock_ctl #(
  parameter int LONG_TMO = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       issValid,
  input  logic [5:0] regIdRs,
  input  logic [5:0] regIdRt,
  input  logic [5:0] regIdRu,
  input  logic [5:0] regIdRv,
  input  logic [5:0] regIdRnA,
  input  logic [5:0] regIdRnB,
  input  logic [1:0] latClsA,
  input  logic [1:0] latClsB,
  input  logic       longDone,
  output logic       stall,
  output logic       longBusy,
  output logic [5:0] longDst,
  output logic       tmoErr
);

  localparam logic [5:0] JX2_GR_ZZR = 6'h3F;
  localparam logic [5:0] JX2_GR_IMM = 6'h3E;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX1/EX2 slot state per lane. EX3 results are already on the writeback
  // path and never interlock, so a slot simply retires when it leaves EX2.
  logic [1:0] ex1_vld_q, ex1_vld_d, ex2_vld_q, ex2_vld_d;
  logic [5:0] ex1_id_q  [2];
  logic [5:0] ex1_id_d  [2];
  logic [5:0] ex2_id_q  [2];
  logic [5:0] ex2_id_d  [2];
  logic [1:0] ex1_cls_q [2];
  logic [1:0] ex1_cls_d [2];
  logic [1:0] ex2_cls_q [2];
  logic [1:0] ex2_cls_d [2];

  logic [0:0]       st_q, st_d;
  logic [5:0]       long_dst_q, long_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [5:0] src  [4];
  logic [5:0] dst  [2];
  logic [1:0] dcls [2];
  logic [3:0] src_live;
  logic [1:0] cls_b_eff;
  logic       long_busy, raw_haz, long_haz, waw_haz, struct_haz;
  logic       accept, long_accept;

  assign src[0] = regIdRs;
  assign src[1] = regIdRt;
  assign src[2] = regIdRu;
  assign src[3] = regIdRv;

  // Lane 2 has no long-op path; class 3 there degrades to a load.
  assign cls_b_eff = (latClsB == 2'd3) ? 2'd2 : latClsB;

  assign dst[0]  = regIdRnA;
  assign dst[1]  = regIdRnB;
  assign dcls[0] = latClsA;
  assign dcls[1] = cls_b_eff;

  assign long_busy = (st_q == ST_BUSY);

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      src_live[s] = issValid && (src[s] != JX2_GR_ZZR) && (src[s] != JX2_GR_IMM);
    end
  end

  always_comb begin
    raw_haz  = 1'b0;
    long_haz = 1'b0;
    waw_haz  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int l = 0; l < 2; l++) begin
        if (src_live[s] && ex1_vld_q[l] && (ex1_id_q[l] == src[s]) && (ex1_cls_q[l] >= 2'd1))
          raw_haz = 1'b1;
        if (src_live[s] && ex2_vld_q[l] && (ex2_id_q[l] == src[s]) && (ex2_cls_q[l] >= 2'd2))
          raw_haz = 1'b1;
      end
      if (src_live[s] && long_busy && (src[s] == long_dst_q))
        long_haz = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      if (dst[d] != JX2_GR_ZZR) begin
        if (long_busy && (dst[d] == long_dst_q))
          long_haz = 1'b1;
        // An older, slower producer of the same register must write back
        // first, otherwise the stale value would land last.
        for (int l = 0; l < 2; l++) begin
          if (ex1_vld_q[l] && (ex1_id_q[l] == dst[d]) && (ex1_cls_q[l] > dcls[d]))
            waw_haz = 1'b1;
          if (ex2_vld_q[l] && (ex2_id_q[l] == dst[d]) && (ex2_cls_q[l] > dcls[d]))
            waw_haz = 1'b1;
        end
      end
    end
  end

  // Uses the registered busy flag, so a second long-op cannot slip in on
  // the cycle the first one completes.
  assign struct_haz  = (latClsA == 2'd3) && long_busy;
  assign stall       = issValid && (raw_haz || long_haz || waw_haz || struct_haz);
  assign accept      = issValid && !stall && !hold;
  assign long_accept = accept && (latClsA == 2'd3);

  // Slot advance
  always_comb begin
    ex1_vld_d = ex1_vld_q;
    ex2_vld_d = ex2_vld_q;
    for (int l = 0; l < 2; l++) begin
      ex1_id_d[l]  = ex1_id_q[l];
      ex1_cls_d[l] = ex1_cls_q[l];
      ex2_id_d[l]  = ex2_id_q[l];
      ex2_cls_d[l] = ex2_cls_q[l];
    end
    if (!hold) begin
      ex2_vld_d = ex1_vld_q;
      for (int l = 0; l < 2; l++) begin
        ex2_id_d[l]  = ex1_id_q[l];
        ex2_cls_d[l] = ex1_cls_q[l];
        ex1_id_d[l]  = dst[l];
        ex1_cls_d[l] = dcls[l];
      end
      // Long-ops are tracked by the FSM, not the slots.
      ex1_vld_d[0] = accept && (regIdRnA != JX2_GR_ZZR) && (latClsA != 2'd3);
      ex1_vld_d[1] = accept && (regIdRnB != JX2_GR_ZZR);
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

`ifdef GPR_INTERLOCK_LONGTMO_EN
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(LONG_TMO);
  logic tmo_q, tmo_d;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, CNT_W'(LONG_TMO)};
`endif

  // Long-op FSM. Completion is honoured even under hold so the result
  // pulse is never dropped; it is applied before a new accept.
  always_comb begin
    st_d       = st_q;
    long_dst_d = long_dst_q;
    cnt_d      = cnt_q;
`ifdef GPR_INTERLOCK_LONGTMO_EN
    tmo_d      = tmo_q;
`endif
    if (long_busy && !hold)
      cnt_d = cnt_inc;
    if (long_busy && longDone) begin
      st_d       = ST_IDLE;
      long_dst_d = JX2_GR_ZZR;
    end
`ifdef GPR_INTERLOCK_LONGTMO_EN
    if (long_busy && !longDone && !hold && (cnt_inc == TMO_CNT)) begin
      st_d       = ST_IDLE;
      long_dst_d = JX2_GR_ZZR;
      tmo_d      = 1'b1;
    end
`endif
    if (long_accept) begin
      st_d       = ST_BUSY;
      long_dst_d = regIdRnA;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex1_vld_q  <= '0;
      ex2_vld_q  <= '0;
      for (int l = 0; l < 2; l++) begin
        ex1_id_q[l]  <= JX2_GR_ZZR;
        ex1_cls_q[l] <= 2'd0;
        ex2_id_q[l]  <= JX2_GR_ZZR;
        ex2_cls_q[l] <= 2'd0;
      end
      st_q       <= ST_IDLE;
      long_dst_q <= JX2_GR_ZZR;
      cnt_q      <= '0;
    end else begin
      ex1_vld_q  <= ex1_vld_d;
      ex2_vld_q  <= ex2_vld_d;
      for (int l = 0; l < 2; l++) begin
        ex1_id_q[l]  <= ex1_id_d[l];
        ex1_cls_q[l] <= ex1_cls_d[l];
        ex2_id_q[l]  <= ex2_id_d[l];
        ex2_cls_q[l] <= ex2_cls_d[l];
      end
      st_q       <= st_d;
      long_dst_q <= long_dst_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef GPR_INTERLOCK_LONGTMO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end
  assign tmoErr = tmo_q;
`else
  assign tmoErr = 1'b0;
`endif

  assign longBusy = long_busy;
  assign longDst  = long_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_interlock_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_interlock_ctl
// Purpose  : Directed self-checking bench for gpr_interlock_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_interlock_ctl;

  localparam logic [5:0] ZZR = 6'h3F;
  localparam logic [5:0] IMM = 6'h3E;

  logic       clock = 1'b0;
  logic       reset, hold, issValid, longDone;
  logic [5:0] regIdRs, regIdRt, regIdRu, regIdRv, regIdRnA, regIdRnB;
  logic [1:0] latClsA, latClsB;
  logic       stall, longBusy, tmoErr;
  logic [5:0] longDst;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  gpr_interlock_ctl #(.LONG_TMO(4), .CNT_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .issValid (issValid),
    .regIdRs  (regIdRs),
    .regIdRt  (regIdRt),
    .regIdRu  (regIdRu),
    .regIdRv  (regIdRv),
    .regIdRnA (regIdRnA),
    .regIdRnB (regIdRnB),
    .latClsA  (latClsA),
    .latClsB  (latClsB),
    .longDone (longDone),
    .stall    (stall),
    .longBusy (longBusy),
    .longDst  (longDst),
    .tmoErr   (tmoErr)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic iss(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] ru,
                     input logic [5:0] rv, input logic [5:0] rna, input logic [5:0] rnb,
                     input logic [1:0] ca, input logic [1:0] cb);
    issValid = 1'b1;
    regIdRs = rs; regIdRt = rt; regIdRu = ru; regIdRv = rv;
    regIdRnA = rna; regIdRnB = rnb; latClsA = ca; latClsB = cb;
    #1;
  endtask

  task automatic idle_in();
    issValid = 1'b0;
    regIdRs = ZZR; regIdRt = ZZR; regIdRu = ZZR; regIdRv = ZZR;
    regIdRnA = ZZR; regIdRnB = ZZR; latClsA = 2'd0; latClsB = 2'd0;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    idle_in();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; longDone = 1'b0;
    idle_in();
    #20;
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_busy",  {7'd0, longBusy}, 8'd0);
    chk("rst_dst",   {2'd0, longDst}, {2'd0, ZZR});
    chk("rst_tmo",   {7'd0, tmoErr}, 8'd0);
    reset = 1'b1;
    tick();

    // Load then use: R4 as EX3 result, consumer stalls two cycles
    iss(ZZR, ZZR, ZZR, ZZR, 6'd4, ZZR, 2'd2, 2'd0);
    chk("lu_prod", {7'd0, stall}, 8'd0);
    tick();
    iss(6'd4, ZZR, ZZR, ZZR, 6'd10, ZZR, 2'd2, 2'd0);
    chk("lu_ex1", {7'd0, stall}, 8'd1);
    tick();
    chk("lu_ex2", {7'd0, stall}, 8'd1);
    tick();
    chk("lu_ex3", {7'd0, stall}, 8'd0);
    tick();
    // Consumer's own destination R10 must now be in EX1
    iss(ZZR, 6'd10, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    chk("lu_entered", {7'd0, stall}, 8'd1);
    drain();

    // EX1-class result is forwardable immediately
    iss(ZZR, ZZR, ZZR, ZZR, 6'd5, ZZR, 2'd0, 2'd0);
    tick();
    iss(ZZR, 6'd5, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    chk("fwd_ex1", {7'd0, stall}, 8'd0);
    tick();
    chk("fwd_ex2", {7'd0, stall}, 8'd0);
    drain();

    // Immediate / zero-register exemption, lane-2 producer R7
    iss(ZZR, ZZR, ZZR, ZZR, ZZR, 6'd7, 2'd0, 2'd2);
    tick();
    iss(IMM, ZZR, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    chk("imm_zzr", {7'd0, stall}, 8'd0);
    iss(ZZR, ZZR, 6'd7, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    chk("ru_hit", {7'd0, stall}, 8'd1);
    issValid = 1'b0; #1;
    chk("novalid", {7'd0, stall}, 8'd0);
    drain();

    // Lane-2 class 3 behaves as a load
    iss(ZZR, ZZR, ZZR, ZZR, ZZR, 6'd8, 2'd0, 2'd3);
    chk("b3_busy_free", {7'd0, stall}, 8'd0);
    tick();
    chk("b3_nobusy", {7'd0, longBusy}, 8'd0);
    iss(6'd8, ZZR, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    tick();
    chk("b3_ex2", {7'd0, stall}, 8'd1);
    tick();
    chk("b3_ex3", {7'd0, stall}, 8'd0);
    drain();

    // WAW: faster write to R11 behind a load to R11
    iss(ZZR, ZZR, ZZR, ZZR, 6'd11, ZZR, 2'd2, 2'd0);
    tick();
    iss(ZZR, ZZR, ZZR, ZZR, ZZR, 6'd11, 2'd0, 2'd0);
    chk("waw_ex1", {7'd0, stall}, 8'd1);
    tick();
    chk("waw_ex2", {7'd0, stall}, 8'd1);
    tick();
    chk("waw_done", {7'd0, stall}, 8'd0);
    drain();

    // Long-op to R9
    iss(ZZR, ZZR, ZZR, ZZR, 6'd9, ZZR, 2'd3, 2'd0);
    chk("lo_accept", {7'd0, stall}, 8'd0);
    tick();
    chk("lo_busy", {7'd0, longBusy}, 8'd1);
    chk("lo_dst",  {2'd0, longDst}, 8'd9);
    iss(ZZR, ZZR, ZZR, 6'd9, ZZR, ZZR, 2'd0, 2'd0);
    chk("lo_use", {7'd0, stall}, 8'd1);
    repeat (3) tick();
    chk("lo_held", {7'd0, stall}, 8'd1);
    iss(ZZR, ZZR, ZZR, ZZR, 6'd12, ZZR, 2'd3, 2'd0);
    chk("lo_struct", {7'd0, stall}, 8'd1);
    iss(ZZR, ZZR, ZZR, ZZR, ZZR, 6'd9, 2'd0, 2'd0);
    chk("lo_dsthaz", {7'd0, stall}, 8'd1);
    // Done arrives during hold and must not be lost
    iss(ZZR, ZZR, ZZR, 6'd9, ZZR, ZZR, 2'd0, 2'd0);
    hold = 1'b1; longDone = 1'b1; #1;
    chk("lo_done_cyc", {7'd0, stall}, 8'd1);
    tick();
    hold = 1'b0; longDone = 1'b0; #1;
    chk("lo_idle", {7'd0, longBusy}, 8'd0);
    chk("lo_dst_rel", {2'd0, longDst}, {2'd0, ZZR});
    chk("lo_release", {7'd0, stall}, 8'd0);
    tick();
    // Stray done while idle is ignored
    idle_in();
    longDone = 1'b1;
    tick();
    longDone = 1'b0;
    chk("lo_stray", {7'd0, longBusy}, 8'd0);
    drain();

    // Hold freeze during a load hazard
    iss(ZZR, ZZR, ZZR, ZZR, 6'd4, ZZR, 2'd2, 2'd0);
    tick();
    iss(6'd4, ZZR, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", {7'd0, stall}, 8'd1);
      tick();
    end
    hold = 1'b0; #1;
    chk("hold_rel_ex1", {7'd0, stall}, 8'd1);
    tick();
    chk("hold_rel_ex2", {7'd0, stall}, 8'd1);
    tick();
    chk("hold_rel_done", {7'd0, stall}, 8'd0);
    drain();

`ifdef GPR_INTERLOCK_LONGTMO_EN
    // Watchdog, LONG_TMO=4: timeout on the 4th counted busy cycle
    iss(ZZR, ZZR, ZZR, ZZR, 6'd15, ZZR, 2'd3, 2'd0);
    tick();
    idle_in();
    repeat (3) tick();
    chk("tmo_still_busy", {7'd0, longBusy}, 8'd1);
    tick();
    chk("tmo_err", {7'd0, tmoErr}, 8'd1);
    chk("tmo_idle", {7'd0, longBusy}, 8'd0);
    chk("tmo_dst", {2'd0, longDst}, {2'd0, ZZR});
    tick();
    chk("tmo_sticky", {7'd0, tmoErr}, 8'd1);
`endif

    // Reset mid-BUSY discards long-op and in-flight slots
    iss(ZZR, ZZR, ZZR, ZZR, 6'd13, 6'd14, 2'd3, 2'd2);
    tick();
    chk("mr_busy", {7'd0, longBusy}, 8'd1);
    idle_in();
    reset = 1'b0; #1;
    chk("mr_busy0", {7'd0, longBusy}, 8'd0);
    chk("mr_dst", {2'd0, longDst}, {2'd0, ZZR});
    chk("mr_tmo", {7'd0, tmoErr}, 8'd0);
    tick();
    reset = 1'b1; #1;
    iss(6'd14, 6'd13, ZZR, ZZR, ZZR, ZZR, 2'd0, 2'd0);
    chk("mr_slots", {7'd0, stall}, 8'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
